sr_pulse_sequencer: RTL and testbench

- Upstream control stage for the team's SR flip-flop. It converts a one-cycle Start request into a timed Set/Reset pulse pair on S and R.
- Sequence: S pulse, hold the flip-flop in set state for On_len cycles, R pulse, then a guard interval before the next request is accepted.
- Used to gate transmit-enable windows in the wireless datapath, with Busy/Done handshake toward the controller.

---
 rtl/sr_seq_pkg.sv | 14 +
 rtl/sr_seq_counter.sv | 38 +++
 rtl/sr_pulse_sequencer.sv | 161 ++++++++++++++++
 tb/tb_sr_pulse_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sr_seq_pkg.sv
// Shared definitions for the SR pulse sequencer: the 3-bit state encoding and
// the default counter width and guard length.
package sr_seq_pkg;

  localparam int CNT_W_DEFAULT = 8;
  localparam int GUARD_DEFAULT = 4;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SET   = 3'd1;
  localparam logic [2:0] HOLD  = 3'd2;
  localparam logic [2:0] RST_P = 3'd3;
  localparam logic [2:0] GUARD = 3'd4;

endpackage

// File: rtl/sr_seq_counter.sv
// Loadable down-counter shared by the HOLD and GUARD phases. It stops at zero
// instead of wrapping, and zero reports the current (registered) value.
module sr_seq_counter #(
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // NOTE: every path through always_comb assigns cnt_d (default first), so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/sr_pulse_sequencer.sv
// Turns a one-cycle Start into a registered S pulse, an On_len-cycle hold, an R
// pulse and a guard gap. Define SR_READBACK_CHECK_EN to add Q_fb/Fb_err checking.
module sr_pulse_sequencer
  import sr_seq_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEFAULT,
  parameter int GUARD_CYCLES = GUARD_DEFAULT
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             Abort,
  input  logic [CNT_W-1:0] On_len,
`ifdef SR_READBACK_CHECK_EN
  input  logic             Q_fb,
  output logic             Fb_err,
`endif
  output logic             S,
  output logic             R,
  output logic             Busy,
  output logic             Done
);

  // The counter is loaded with one less than the phase length and the phase
  // ends on the cycle it reads zero, so HOLD lasts L cycles and GUARD lasts
  // GUARD_CYCLES cycles without ever wrapping.
  localparam logic [CNT_W-1:0] GUARD_LOAD =
    (GUARD_CYCLES > 0) ? CNT_W'(GUARD_CYCLES - 1) : '0;

  logic [2:0]       state_q, state_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept;
  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;
  logic [CNT_W-1:0] hold_load;

  // On_len = 0 behaves as a one-cycle hold.
  assign hold_load = (On_len == '0) ? '0 : On_len - CNT_W'(1);

  sr_seq_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .Clk      (Clk),
    .Rst      (Rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    case (state_q)
      IDLE: begin
        // Abort beats a simultaneous Start; the request is dropped, not queued.
        if (Start && !Abort) begin
          accept   = 1'b1;
          state_d  = SET;
          cnt_load = 1'b1;
          cnt_val  = hold_load;
        end
      end
      SET: begin
        state_d = Abort ? RST_P : HOLD;
      end
      HOLD: begin
        if (Abort || cnt_zero) begin
          state_d = RST_P;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RST_P: begin
        if (GUARD_CYCLES > 0) begin
          state_d  = GUARD;
          cnt_load = 1'b1;
          cnt_val  = GUARD_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      GUARD: begin
        if (cnt_zero) begin
          state_d = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so each one is a
  // clean flop output that lines up with the state it describes.
  always_comb begin
    s_d    = (state_d == SET);
    r_d    = (state_d == RST_P);
    busy_d = (state_d != IDLE);
    done_d = (state_d == IDLE) && ((state_q == RST_P) || (state_q == GUARD));
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign S    = s_q;
  assign R    = r_q;
  assign Busy = busy_q;
  assign Done = done_q;

`ifdef SR_READBACK_CHECK_EN
  logic after_rp_q, after_rp_d;
  logic fb_err_q, fb_err_d;
  logic fb_hit;

  // Q must read 1 throughout HOLD and 0 once the R pulse has landed. A fault
  // seen in the same cycle a new Start is accepted is still recorded.
  always_comb begin
    after_rp_d = (state_q == RST_P);
    fb_hit     = ((state_q == HOLD) && !Q_fb) || (after_rp_q && Q_fb);
    fb_err_d   = (accept ? 1'b0 : fb_err_q) | fb_hit;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      after_rp_q <= 1'b0;
      fb_err_q   <= 1'b0;
    end else begin
      after_rp_q <= after_rp_d;
      fb_err_q   <= fb_err_d;
    end
  end

  assign Fb_err = fb_err_q;
`endif

endmodule

// File: tb/tb_sr_pulse_sequencer.sv
// Bench for sr_pulse_sequencer: two instances (guard 4 and guard 0) share the
// stimulus and are compared every cycle against a pulse-schedule model.
module tb_sr_pulse_sequencer;

  localparam int CNT_W = 8;
  localparam int NDUT  = 2;

  logic             Clk = 1'b0;
  logic             Rst;
  logic             Start;
  logic             Abort;
  logic [CNT_W-1:0] On_len;

  logic s_a, r_a, busy_a, done_a;
  logic s_b, r_b, busy_b, done_b;

  always #5 Clk = ~Clk;

  sr_pulse_sequencer #(
    .CNT_W        (CNT_W),
    .GUARD_CYCLES (4)
  ) u_dut_g4 (
    .Clk    (Clk),
    .Rst    (Rst),
    .Start  (Start),
    .Abort  (Abort),
    .On_len (On_len),
    .S      (s_a),
    .R      (r_a),
    .Busy   (busy_a),
    .Done   (done_a)
  );

  sr_pulse_sequencer #(
    .CNT_W        (CNT_W),
    .GUARD_CYCLES (0)
  ) u_dut_g0 (
    .Clk    (Clk),
    .Rst    (Rst),
    .Start  (Start),
    .Abort  (Abort),
    .On_len (On_len),
    .S      (s_b),
    .R      (r_b),
    .Busy   (busy_b),
    .Done   (done_b)
  );

  int n_cmp;
  int n_err;
  int e;

  // Reference model: each accepted window is a schedule of edge numbers. The
  // outputs visible after edge x are derived by comparing x with that schedule.
  bit act [NDUT];
  int s_e [NDUT];
  int r_e [NDUT];

  function automatic int guard_of(input int k);
    return (k == 0) ? 4 : 0;
  endfunction

  function automatic bit busy_at(input int k, input int x);
    return act[k] && (x >= s_e[k]) && (x <= r_e[k] + guard_of(k));
  endfunction

  function automatic bit exp_s(input int k);
    return act[k] && (e == s_e[k]);
  endfunction

  function automatic bit exp_r(input int k);
    return act[k] && (e == r_e[k]);
  endfunction

  function automatic bit exp_done(input int k);
    return act[k] && (e == r_e[k] + guard_of(k) + 1);
  endfunction

  task automatic model_edge(input logic st, input logic ab, input logic rs, input int len);
    for (int k = 0; k < NDUT; k++) begin
      bit was_busy;
      int l_eff;
      was_busy = busy_at(k, e - 1);
      if (rs) begin
        act[k] = 1'b0;
        s_e[k] = -1000;
        r_e[k] = -1000;
      end else if (ab && act[k] && (e > s_e[k]) && (e <= r_e[k])) begin
        r_e[k] = e;
      end else if (st && !ab && !was_busy) begin
        l_eff  = (len == 0) ? 1 : len;
        act[k] = 1'b1;
        s_e[k] = e;
        r_e[k] = e + l_eff + 1;
      end
    end
  endtask

  task automatic check(input string tag, input int k, input logic got, input logic exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s dut%0d edge %0d: observed=%b expected=%b", tag, k, e, got, exp);
    end
  endtask

  task automatic step(input logic st, input logic ab, input logic rs, input int len);
    Start  = st;
    Abort  = ab;
    Rst    = rs;
    On_len = CNT_W'(len);
    @(posedge Clk);
    e++;
    model_edge(st, ab, rs, len);
    #1;
    check("S",    0, s_a,    exp_s(0));
    check("R",    0, r_a,    exp_r(0));
    check("Busy", 0, busy_a, busy_at(0, e));
    check("Done", 0, done_a, exp_done(0));
    check("S",    1, s_b,    exp_s(1));
    check("R",    1, r_b,    exp_r(1));
    check("Busy", 1, busy_b, busy_at(1, e));
    check("Done", 1, done_b, exp_done(1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 1'b0, 0);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    e      = 0;
    Rst    = 1'b1;
    Start  = 1'b0;
    Abort  = 1'b0;
    On_len = '0;
    for (int k = 0; k < NDUT; k++) begin
      act[k] = 1'b0;
      s_e[k] = -1000;
      r_e[k] = -1000;
    end

    // Reset state
    step(1'b0, 1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 1'b1, 0);
    idle(2);

    // Basic window, On_len = 3
    step(1'b1, 1'b0, 1'b0, 3);
    idle(12);

    // On_len = 0 treated as 1
    step(1'b1, 1'b0, 1'b0, 0);
    idle(10);

    // Abort in HOLD at t0+4
    step(1'b1, 1'b0, 1'b0, 10);
    idle(3);
    step(1'b0, 1'b1, 0, 0);
    idle(10);

    // Abort during SET
    step(1'b1, 1'b0, 1'b0, 5);
    step(1'b0, 1'b1, 1'b0, 0);
    idle(8);

    // Start pulses while busy are ignored
    step(1'b1, 1'b0, 1'b0, 5);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b0, 2);
    end
    idle(10);

    // Start and Abort together in IDLE
    step(1'b1, 1'b1, 1'b0, 3);
    idle(5);

    // Reset mid-HOLD, then immediate restart
    step(1'b1, 1'b0, 1'b0, 6);
    idle(2);
    step(1'b0, 1'b0, 1'b1, 0);
    step(1'b1, 1'b0, 1'b0, 2);
    idle(10);

    // Continuous Start: each new window is accepted in the Done cycle
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 1'b0, 1);
    end
    idle(8);

    // Maximum hold length
    step(1'b1, 1'b0, 1'b0, 255);
    idle(265);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic st;
      logic ab;
      logic rs;
      int   len;
      st  = ($urandom_range(0, 3) == 0);
      ab  = ($urandom_range(0, 19) == 0);
      rs  = ($urandom_range(0, 99) == 0);
      len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
      step(st, ab, rs, len);
    end
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
